// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E/D-stage request lines and HI/LO/busy/stall results between the pipeline and the MDU.
interface mdu_ctrl_if #(parameter int WIDTH = 32);
  logic [2:0]       e_mdOp;
  logic [WIDTH-1:0] e_rs;
  logic [WIDTH-1:0] e_rt;
  logic             d_md_use;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output e_mdOp, e_rs, e_rt, d_md_use, input busy, stall, hi, lo);
  modport slave  (input e_mdOp, e_rs, e_rt, d_md_use, output busy, stall, hi, lo);
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: fixed-latency multiply/divide sequencer owning HI/LO and the D-stage stall request.
module mdu_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic         clk,
  input logic         reset,
  mdu_ctrl_if.slave   md
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;
  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [WIDTH-1:0]         hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
  logic                     pwe_q, pwe_d;
  logic                     is_md, is_mul, start;
  logic [2*WIDTH-1:0]       smul, umul;
  logic [WIDTH-1:0]         dv, uq, ur, res_hi, res_lo;
  logic signed [WIDTH-1:0]  sq, sr;
  assign is_md  = md.e_mdOp >= 3'd1 && md.e_mdOp <= 3'd4;
  assign is_mul = md.e_mdOp == 3'd1 || md.e_mdOp == 3'd2;
  assign start  = state_q == IDLE && is_md;
  assign smul = {{WIDTH{md.e_rs[WIDTH-1]}}, md.e_rs} * {{WIDTH{md.e_rt[WIDTH-1]}}, md.e_rt};
  assign umul = {{WIDTH{1'b0}}, md.e_rs} * {{WIDTH{1'b0}}, md.e_rt};
  // Divisor forced to 1 for /0 (result discarded) and for MIN/-1, where rs/1 gives the required lo=MIN, hi=0.
  assign dv = (md.e_rt == '0 || (md.e_rt == '1 && md.e_rs == {1'b1, {(WIDTH-1){1'b0}}}))
              ? WIDTH'(1) : md.e_rt;
  assign sq = $signed(md.e_rs) / $signed(dv);
  assign sr = $signed(md.e_rs) % $signed(dv);
  assign uq = md.e_rs / (md.e_rt == '0 ? WIDTH'(1) : md.e_rt);
  assign ur = md.e_rs % (md.e_rt == '0 ? WIDTH'(1) : md.e_rt);
  always_comb begin
    res_hi = md.e_mdOp == 3'd1 ? smul[2*WIDTH-1:WIDTH] : md.e_mdOp == 3'd2 ? umul[2*WIDTH-1:WIDTH] :
             md.e_mdOp == 3'd3 ? WIDTH'(sr) : ur;
    res_lo = md.e_mdOp == 3'd1 ? smul[WIDTH-1:0] : md.e_mdOp == 3'd2 ? umul[WIDTH-1:0] :
             md.e_mdOp == 3'd3 ? WIDTH'(sq) : uq;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwe_d   = pwe_q;
    if (start) begin
      phi_d   = res_hi;
      plo_d   = res_lo;
      pwe_d   = is_mul || md.e_rt != '0;
      cnt_d   = is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
      state_d = is_mul ? MULT : DIV;
    end else if (state_q == IDLE) begin
      hi_d = md.e_mdOp == 3'd5 ? md.e_rs : hi_q;
      lo_d = md.e_mdOp == 3'd6 ? md.e_rs : lo_q;
    end else if (cnt_q == '0) begin
      hi_d    = pwe_q ? phi_q : hi_q;
      lo_d    = pwe_q ? plo_q : lo_q;
      state_d = IDLE;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      pwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwe_q   <= pwe_d;
    end
  end
  assign md.busy  = state_q != IDLE;
  assign md.stall = md.d_md_use && (md.busy || is_md);
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit controller for the 5-stage MIPS pipeline.
- Accepts MDU instructions in the E stage and sequences a fixed-latency multi-cycle multiply or divide.
- Owns the HI/LO registers and drives the stall request that holds the D stage while an MDU instruction would hit a busy unit.
- Sits beside the E-stage ALU; the hazard unit ORs `stall` into its global stall.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; one clock, no other clock domains.
- e_mdOp  input  3  E-stage MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- e_rs  input  WIDTH  E-stage forwarded rs value.
- e_rt  input  WIDTH  E-stage forwarded rt value.
- d_md_use  input  1  D-stage instruction is any MDU op (mult/multu/div/divu/mfhi/mflo/mthi/mtlo).
- busy  output  1  multi-cycle operation in progress.
- stall  output  1  D-stage stall request.
- hi  output  WIDTH  HI register (read by mfhi in E).
- lo  output  WIDTH  LO register (read by mflo in E).

Behaviour:
- Reset (reset low, asynchronous, any state including mid-operation):
  - state IDLE, counter 0, busy 0, hi 0, lo 0, pending result 0.
  - Any in-flight operation is discarded.
  - On reset release the controller accepts ops from the first rising edge.
- States:
  - IDLE: `start` = e_mdOp in 1..4. On a rising edge with start, latch the computed result into pending regs and load counter with MULT_CYCLES-1 or DIV_CYCLES-1. Go to MULT or DIV.
  - MULT / DIV: the counter decrements each edge. On the edge where counter==0, commit pending to HI/LO and return to IDLE.
- Timing: op sampled at edge T.
  - busy=1 from after edge T until edge T+N, where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO change exactly at edge T+N; busy falls at the same edge.
- Arithmetic:
  - mult: signed 2W-bit product; hi=upper W bits, lo=lower W bits.
  - multu: same, unsigned.
  - div: lo=signed quotient (truncated toward zero), hi=signed remainder (sign of dividend).
  - divu: lo/hi = unsigned quotient/remainder.
  - Divisor 0: the operation still runs DIV_CYCLES with busy, but HI/LO are left unchanged at commit.
  - div of -2^(W-1) by -1: lo=-2^(W-1), hi=0.
- mthi/mtlo:
  - In IDLE, write e_rs into hi/lo at the next edge; no busy.
  - While busy, ignored (stall guarantees they never arrive).
- An op 1..4 arriving while busy is ignored; the current op continues unchanged.
- stall (combinational) = d_md_use && (busy || e_mdOp in 1..4).
  - Stall also covers the start cycle, so mfhi/mflo never read stale HI/LO.
  - d_md_use with busy=0 and no E-stage start gives stall=0.
- hi/lo are pure register outputs. No bypass of a same-edge mthi/mtlo.
- Back-to-back ops: the edge that returns to IDLE does not accept a new op. The next op starts on a later edge; stall ensures the pipeline provides it then.

Test Plan:
- Reset, mult: reset low then high; mult e_rs=0xFFFFFFFE, e_rt=3 for one cycle, then none -> busy high 5 cycles; at edge T+5 hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy 0.
- multu: e_rs=0xFFFFFFFF, e_rt=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- div / divu:
  - div e_rs=-7 (0xFFFFFFF9), e_rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu 7/0 -> busy 10 cycles; hi/lo unchanged.
- Stall: d_md_use=1 during start cycle and all 5 mult busy cycles -> stall=1 on those 6 cycles, 0 after busy falls. d_md_use=0 -> stall=0 throughout.
- mthi/mtlo: mthi e_rs=0x12345678, then mtlo e_rs=0x9ABCDEF0 -> hi/lo updated on successive edges, busy never asserts. mthi issued while busy -> ignored.
- Reset mid-op: start div, assert reset at cycle 4 -> busy, hi, lo go 0 immediately (asynchronous); after release, no commit occurs at original T+10.
